// File: rtl/sar_adc_controller.sv
// Successive-approximation sequencer for the PWM/RC-filter ADC front end.
// It drives trial codes as PWM duty and resolves one bit per settle window, MSB first.
module sar_adc_controller #(
   parameter int WIDTH          = 8,
   parameter int PRESCALE       = 4,
   parameter int SETTLE_PERIODS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             pwm_compare,
   output logic             pwm_out,
   output logic [WIDTH-1:0] trial_code,
   output logic [WIDTH-1:0] sar_adc_result,
   output logic             sar_conversion_done,
   output logic             busy
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int SW = (SETTLE_PERIODS > 1) ? $clog2(SETTLE_PERIODS) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [PW-1:0]    PRE_LAST    = PW'(PRESCALE - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_PERIODS - 1);
   localparam logic [BW-1:0]    BIT_MSB     = BW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] TRIAL_MSB   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] CNT_LAST    = {WIDTH{1'b1}};

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_CONVERT = 1'b1;

   logic             cmp_meta;
   logic             cmp_s;
   logic [PW-1:0]    presc_cnt;
   logic             tick;
   logic [WIDTH-1:0] pwm_cnt;
   logic             wrap;
   logic [WIDTH-1:0] duty;
   logic [0:0]       state;
   logic [WIDTH-1:0] trial;
   logic [BW-1:0]    bit_idx;
   logic [SW-1:0]    settle_cnt;

   logic [0:0]       state_nxt;
   logic [WIDTH-1:0] trial_nxt;
   logic [BW-1:0]    bit_nxt;
   logic [SW-1:0]    settle_nxt;
   logic [WIDTH-1:0] resolved;
   logic             finish;

   assign tick       = (presc_cnt == PRE_LAST);
   assign wrap       = tick && (pwm_cnt == CNT_LAST);
   assign trial_code = trial;
   assign busy       = (state == ST_CONVERT);

   // Every state/trial change is gated by wrap, so the filter always sees whole PWM periods.
   always_comb begin
      state_nxt  = state;
      trial_nxt  = trial;
      bit_nxt    = bit_idx;
      settle_nxt = settle_cnt;
      finish     = 1'b0;
      resolved   = trial;
      if (!cmp_s) begin
         resolved[bit_idx] = 1'b0;
      end
      if (wrap) begin
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state_nxt  = ST_CONVERT;
                  trial_nxt  = TRIAL_MSB;
                  bit_nxt    = BIT_MSB;
                  settle_nxt = '0;
               end
            end
            default: begin
               if (settle_cnt == SETTLE_LAST && bit_idx == '0) begin
                  // Final decision completes even if enable has just dropped.
                  finish = 1'b1;
                  if (enable) begin
                     trial_nxt  = TRIAL_MSB;
                     bit_nxt    = BIT_MSB;
                     settle_nxt = '0;
                  end else begin
                     state_nxt  = ST_IDLE;
                     trial_nxt  = '0;
                     bit_nxt    = '0;
                     settle_nxt = '0;
                  end
               end else if (!enable) begin
                  state_nxt  = ST_IDLE;
                  trial_nxt  = '0;
                  bit_nxt    = '0;
                  settle_nxt = '0;
               end else if (settle_cnt != SETTLE_LAST) begin
                  settle_nxt = settle_cnt + 1'b1;
               end else begin
                  trial_nxt                  = resolved;
                  trial_nxt[bit_idx - 1'b1]  = 1'b1;
                  bit_nxt                    = bit_idx - 1'b1;
                  settle_nxt                 = '0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmp_meta            <= 1'b0;
         cmp_s               <= 1'b0;
         presc_cnt           <= '0;
         pwm_cnt             <= '0;
         pwm_out             <= 1'b0;
         duty                <= '0;
         state               <= ST_IDLE;
         trial               <= '0;
         bit_idx             <= '0;
         settle_cnt          <= '0;
         sar_adc_result      <= '0;
         sar_conversion_done <= 1'b0;
      end else begin
         cmp_meta   <= pwm_compare;
         cmp_s      <= cmp_meta;
         presc_cnt  <= tick ? '0 : presc_cnt + 1'b1;
         if (tick) begin
            pwm_cnt <= pwm_cnt + 1'b1;
         end
         pwm_out    <= (pwm_cnt < duty);
         if (wrap) begin
            duty <= trial_nxt;
         end
         state      <= state_nxt;
         trial      <= trial_nxt;
         bit_idx    <= bit_nxt;
         settle_cnt <= settle_nxt;
         sar_conversion_done <= finish;
         if (finish) begin
            sar_adc_result <= resolved;
         end
      end
   end

endmodule

// File: tb/tb_sar_adc_controller.sv
// Self-checking bench for sar_adc_controller: period-level reference model compared every cycle,
// plus directed checks on trial sequence, boundaries, PWM shape, abort and async reset.
module tb_sar_adc_controller;

   localparam int WIDTH  = 8;
   localparam int PRESC  = 1;
   localparam int SETTLE = 2;
   localparam int PERIOD = (1 << WIDTH) * PRESC;
   localparam int CONV   = WIDTH * SETTLE * PERIOD;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             pwm_compare;
   logic             pwm_out;
   logic [WIDTH-1:0] trial_code;
   logic [WIDTH-1:0] sar_adc_result;
   logic             sar_conversion_done;
   logic             busy;
   logic [WIDTH-1:0] vin = '0;

   int compared   = 0;
   int mismatched = 0;

   sar_adc_controller #(
      .WIDTH(WIDTH),
      .PRESCALE(PRESC),
      .SETTLE_PERIODS(SETTLE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .pwm_compare(pwm_compare),
      .pwm_out(pwm_out),
      .trial_code(trial_code),
      .sar_adc_result(sar_adc_result),
      .sar_conversion_done(sar_conversion_done),
      .busy(busy)
   );

   // Ideal comparator: analog input at or above the filtered PWM level.
   assign pwm_compare = (trial_code <= vin);

   always #5 clk = ~clk;

   // Reference model in terms of clock edges since reset and whole PWM periods since the start wrap.
   int unsigned      n;
   bit               m_active;
   int unsigned      m_start;
   logic [WIDTH-1:0] m_code;
   logic [WIDTH-1:0] m_result;
   logic [WIDTH-1:0] e_trial;
   bit               e_done;
   bit               e_pwm;
   int unsigned      m_p;
   int               m_bit;
   logic [WIDTH-1:0] m_t;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         n = 0; m_active = 0; m_start = 0; m_code = '0; m_result = '0;
         e_trial = '0; e_done = 0; e_pwm = 0;
      end else begin
         n++;
         // Duty tracks the trial code period by period, and pwm_out is one register behind.
         e_pwm  = (((n - 1) % PERIOD) / PRESC) < int'(e_trial);
         e_done = 0;
         if (n % PERIOD == 0) begin
            if (!m_active) begin
               if (enable) begin
                  m_active = 1; m_start = n; m_code = '0;
               end
            end else begin
               m_p   = (n - m_start) / PERIOD;
               m_bit = WIDTH - int'(m_p / SETTLE);
               if (m_p % SETTLE == 0 && m_bit == 0) begin
                  if ((m_code | 1) <= vin) m_code = m_code | 1;
                  m_result = m_code;
                  e_done   = 1;
                  if (enable) begin
                     m_start = n; m_code = '0;
                  end else begin
                     m_active = 0;
                  end
               end else if (!enable) begin
                  m_active = 0;
               end else if (m_p % SETTLE == 0) begin
                  m_t = m_code | (WIDTH'(1) << m_bit);
                  if (m_t <= vin) m_code = m_t;
               end
            end
         end
         if (m_active)
            e_trial = m_code | (WIDTH'(1) << (WIDTH - 1 - int'((n - m_start) / PERIOD / SETTLE)));
         else
            e_trial = '0;
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [2*WIDTH+2:0] got, req;
      got = {trial_code, sar_adc_result, sar_conversion_done, busy, pwm_out};
      req = {e_trial, m_result, e_done, m_active, e_pwm};
      compared++;
      if (got !== req) begin
         mismatched++;
         $display("FAIL model_cycle t=%0t: got trial=%h result=%h done=%b busy=%b pwm=%b required trial=%h result=%h done=%b busy=%b pwm=%b",
                  $time, trial_code, sar_adc_result, sar_conversion_done, busy, pwm_out,
                  e_trial, m_result, e_done, m_active, e_pwm);
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      compared++;
      if (got !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h required %0h", name, got, req);
      end
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (!sar_conversion_done && c < budget);
      check("done_arrives", 32'(sar_conversion_done), 32'd1);
   endtask

   task automatic wait_busy(input logic level, input int budget);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (busy !== level && c < budget);
      check("busy_level", 32'(busy), 32'(level));
   endtask

   task automatic wait_trial(input logic [WIDTH-1:0] code, input int budget);
      int c = 0;
      do begin
         @(negedge clk);
         c++;
      end while (trial_code !== code && c < budget);
      check("trial_reached", 32'(trial_code), 32'(code));
   endtask

   logic [WIDTH-1:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
   logic [WIDTH-1:0] bounds [3] = '{8'h00, 8'hFF, 8'h80};

   initial begin
      int cnt;
      int highs;
      int dones;
      logic [WIDTH-1:0] rnd;

      repeat (3) @(negedge clk);
      check("reset_outputs", {trial_code, sar_adc_result, sar_conversion_done, busy, pwm_out}, 32'd0);
      reset = 1'b0;

      // Idle with enable low: nothing moves for more than a PWM period.
      highs = 0;
      repeat (PERIOD + 20) begin
         @(negedge clk);
         if (pwm_out) highs++;
      end
      check("idle_pwm_highs", highs, 0);

      vin    = 8'hA5;
      enable = 1'b1;
      wait_busy(1'b1, PERIOD + 10);
      repeat (PERIOD / 2) @(negedge clk);
      for (int i = 0; i < WIDTH; i++) begin
         check($sformatf("trial_seq_%0d", i), trial_code, seq_a5[i]);
         if (i < WIDTH - 1) repeat (SETTLE * PERIOD) @(negedge clk);
      end
      wait_done(CONV);
      check("result_a5", sar_adc_result, 8'hA5);

      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!sar_conversion_done && cnt < CONV + 100);
      check("done_interval", cnt, CONV);

      for (int i = 0; i < 3; i++) begin
         vin = bounds[i];
         wait_done(CONV + 100);
         check($sformatf("boundary_%0h", bounds[i]), sar_adc_result, bounds[i]);
      end

      // Next conversion is holding 0x80: exactly half of one period is high.
      repeat (4) @(negedge clk);
      check("pwm_trial", trial_code, 8'h80);
      highs = 0;
      repeat (PERIOD) begin
         @(negedge clk);
         if (pwm_out) highs++;
      end
      check("pwm_half_duty", highs, PERIOD / 2);

      // Drop enable while the third bit is under test.
      wait_trial(8'hA0, CONV);
      repeat (100) @(negedge clk);
      enable = 1'b0;
      wait_busy(1'b0, PERIOD + 10);
      check("abort_pwm", pwm_out, 1'b0);
      check("abort_trial", trial_code, 8'h00);
      check("abort_keeps_result", sar_adc_result, 8'h80);
      highs = 0;
      dones = 0;
      repeat (3 * PERIOD) begin
         @(negedge clk);
         if (pwm_out) highs++;
         if (sar_conversion_done) dones++;
      end
      check("abort_no_done", dones, 0);
      check("abort_idle_pwm", highs, 0);

      rnd    = WIDTH'($urandom_range(1, 254));
      vin    = rnd;
      enable = 1'b1;
      wait_busy(1'b1, PERIOD + 10);
      check("restart_msb", trial_code, 8'h80);

      // Async reset between clock edges, partway into a conversion.
      repeat ($urandom_range(600, 3000)) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      #1 check("async_reset_clears", {trial_code, sar_adc_result, sar_conversion_done, busy, pwm_out}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      wait_done(CONV + PERIOD + 10);
      check("post_reset_result", sar_adc_result, 32'(rnd));

      vin = 8'h3C;
      wait_done(CONV + 100);
      check("result_3c", sar_adc_result, 8'h3C);
      @(negedge clk);
      check("done_width_3c", sar_conversion_done, 1'b0);
      vin = 8'hC3;
      wait_done(CONV + 100);
      check("result_c3", sar_adc_result, 8'hC3);
      @(negedge clk);
      check("done_width_c3", sar_conversion_done, 1'b0);

      enable = 1'b0;
      repeat (PERIOD + 10) @(negedge clk);
      check("final_idle", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
